// File: rtl/stage_if_prefetch.sv
// IF stage: clocked fetch FSM feeding a DEPTH-entry {pc, inst} prefetch FIFO.
// Define IF_BYPASS_EN to forward a push into an empty FIFO straight to IF/ID.
module stage_if_prefetch #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INST_W   = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_busy,
   input  logic              mem_done,
   input  logic [INST_W-1:0] mem_data,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              stall,
   output logic              valid_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic [INST_W-1:0] inst_o,
   output logic              stallreq
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 2;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

   state_e state_q, state_d;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW:0]       count_q, count_d;
   logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
   logic [INST_W-1:0] fifo_inst_q [DEPTH];

   logic          empty, push, pop, byp;
   logic          wr_en, rd_en;
   logic          issue_idle, issue_next;
   logic [CW-1:0] cnt_ext, pop_ext;

   assign empty = (count_q == '0);
   assign push  = (state_q == REQ) && mem_done && !redirect;

`ifdef IF_BYPASS_EN
   assign byp     = push && empty;
   assign valid_o = !empty || byp;
   assign pc_o    = byp ? addr_q : fifo_pc_q[rd_ptr_q];
   assign inst_o  = byp ? mem_data : fifo_inst_q[rd_ptr_q];
`else
   assign byp     = 1'b0;
   assign valid_o = !empty;
   assign pc_o    = fifo_pc_q[rd_ptr_q];
   assign inst_o  = fifo_inst_q[rd_ptr_q];
`endif

   assign stallreq = !valid_o;
   assign pop      = valid_o && !stall && !redirect;
   assign rd_en    = pop && !empty;
   assign wr_en    = push && !(byp && !stall);

   // Space checks look ahead at this cycle's pop/push.
   assign cnt_ext    = CW'(count_q);
   assign pop_ext    = CW'(pop);
   assign issue_idle = !mem_busy && !redirect
                       && ((cnt_ext - pop_ext) < DEPTH_C);
   assign issue_next = !mem_busy
                       && ((cnt_ext + CW'(1) - pop_ext) < DEPTH_C);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (issue_idle) state_d = REQ;
         end
         REQ: begin
            if (redirect)
               state_d = mem_done ? IDLE : DROP;
            else if (mem_done)
               state_d = issue_next ? REQ : IDLE;
         end
         DROP: begin
            if (mem_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_re = (state_q == REQ);
   end

   assign mem_addr = addr_q;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      addr_d     = addr_q;
      if (redirect)
         fetch_pc_d = redirect_pc;
      else if (push)
         fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      if (state_q == IDLE && issue_idle)
         addr_d = fetch_pc_q;
      else if (push && issue_next)
         addr_d = fetch_pc_q + ADDR_W'(4);
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q + PW'(rd_en);
      wr_ptr_d = wr_ptr_q + PW'(wr_en);
      count_d  = count_q + (PW+1)'(wr_en) - (PW+1)'(rd_en);
      if (redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         addr_q     <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_pc_q[i]   <= '0;
            fifo_inst_q[i] <= '0;
         end
      end else if (wr_en) begin
         fifo_pc_q[wr_ptr_q]   <= addr_q;
         fifo_inst_q[wr_ptr_q] <= mem_data;
      end
   end

endmodule
